// File: rtl/eth10base_t_rx.sv
`default_nettype none
// ============================================================================
// Module   : eth10base_t_rx
// Brief    : 10BASE-T receive path - Manchester decode, SFD strip, NLP link.
// Revision : 1.0 - initial release
// ============================================================================
module eth10base_t_rx #(
   parameter int CLK_PER_BIT  = 8,
   parameter int LINK_TIMEOUT = 4000000,
   parameter int NLP_MIN      = 4,
   parameter int NLP_MAX      = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_dv,
   output logic       rx_eof,
   output logic       rx_dribble,
   output logic       link_ok,
   output logic       nlp_seen
);

   localparam int c_Q3  = (3 * CLK_PER_BIT) / 4;
   localparam int c_EOC = (3 * CLK_PER_BIT) / 2;
   localparam int c_BW  = $clog2(c_EOC + 1);
   localparam int c_PW  = $clog2(NLP_MAX + 2);
   localparam int c_LW  = $clog2(CLK_PER_BIT + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HUNT = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t          r_state, w_state_nx;
   logic            r_sync1, r_sync2, r_prev;
   logic [c_BW-1:0] r_bit_cnt, w_bit_cnt_nx;
   logic [c_PW-1:0] r_pw, w_pw_nx;
   logic [c_LW-1:0] r_low_cnt, w_low_cnt_nx;
   logic            r_in_pulse, w_in_pulse_nx;
   logic            r_low_wait, w_low_wait_nx;
   logic [7:0]      r_shift, w_shift_nx;
   logic [7:0]      r_data, w_data_nx;
   logic [2:0]      r_bcnt, w_bcnt_nx;
   logic            r_valid, w_valid_nx;
   logic            r_dv, w_dv_nx;
   logic            r_eof, w_eof_nx;
   logic            r_dribble, w_dribble_nx;
   logic            r_nlp, w_nlp_nx;
   logic            r_link_ok, r_have_nlp;
   logic [31:0]     r_tmr;
   logic            w_edge, w_rise, w_fall, w_mid, w_eoc;
   logic [7:0]      w_shifted;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
      end else begin
         r_sync1 <= rxd;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
      end
   end

   assign w_edge    = r_sync2 ^ r_prev;
   assign w_rise    = w_edge & r_sync2;
   assign w_fall    = w_edge & ~r_sync2;
   assign w_mid     = w_edge && (r_bit_cnt >= c_BW'(c_Q3));
   assign w_eoc     = !w_edge && (r_bit_cnt == c_BW'(c_EOC));
   assign w_shifted = {r_sync2, r_shift[7:1]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= '0;
         r_pw       <= '0;
         r_low_cnt  <= '0;
         r_in_pulse <= 1'b0;
         r_low_wait <= 1'b0;
         r_shift    <= 8'h00;
         r_data     <= 8'h00;
         r_bcnt     <= 3'd0;
         r_valid    <= 1'b0;
         r_dv       <= 1'b0;
         r_eof      <= 1'b0;
         r_dribble  <= 1'b0;
         r_nlp      <= 1'b0;
      end else begin
         r_state    <= w_state_nx;
         r_bit_cnt  <= w_bit_cnt_nx;
         r_pw       <= w_pw_nx;
         r_low_cnt  <= w_low_cnt_nx;
         r_in_pulse <= w_in_pulse_nx;
         r_low_wait <= w_low_wait_nx;
         r_shift    <= w_shift_nx;
         r_data     <= w_data_nx;
         r_bcnt     <= w_bcnt_nx;
         r_valid    <= w_valid_nx;
         r_dv       <= w_dv_nx;
         r_eof      <= w_eof_nx;
         r_dribble  <= w_dribble_nx;
         r_nlp      <= w_nlp_nx;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_bit_cnt_nx  = r_bit_cnt;
      w_pw_nx       = r_pw;
      w_low_cnt_nx  = r_low_cnt;
      w_in_pulse_nx = r_in_pulse;
      w_low_wait_nx = r_low_wait;
      w_shift_nx    = r_shift;
      w_data_nx     = r_data;
      w_bcnt_nx     = r_bcnt;
      w_valid_nx    = 1'b0;
      w_dv_nx       = r_dv;
      w_eof_nx      = 1'b0;
      w_dribble_nx  = 1'b0;
      w_nlp_nx      = 1'b0;
      if (r_bit_cnt != c_BW'(c_EOC)) begin
         w_bit_cnt_nx = r_bit_cnt + c_BW'(1);
      end

      case (r_state)
         ST_IDLE: begin
            if (r_low_wait) begin
               // An edge this soon after a pulse means Manchester carrier;
               // that edge is the first mid-bit edge of the frame.
               if (w_edge) begin
                  w_state_nx    = ST_HUNT;
                  w_low_wait_nx = 1'b0;
                  w_bit_cnt_nx  = c_BW'(1);
                  w_shift_nx    = {r_sync2, 7'd0};
               end else if (r_low_cnt == c_LW'(CLK_PER_BIT - 1)) begin
                  w_low_wait_nx = 1'b0;
                  w_nlp_nx      = 1'b1;
               end else begin
                  w_low_cnt_nx = r_low_cnt + c_LW'(1);
               end
            end else if (r_in_pulse) begin
               if (w_fall) begin
                  w_in_pulse_nx = 1'b0;
                  if ((r_pw >= c_PW'(NLP_MIN)) && (r_pw <= c_PW'(NLP_MAX))) begin
                     w_low_wait_nx = 1'b1;
                     w_low_cnt_nx  = '0;
                  end
               end else if (r_pw != c_PW'(NLP_MAX + 1)) begin
                  w_pw_nx = r_pw + c_PW'(1);
               end
            end else if (w_rise) begin
               w_in_pulse_nx = 1'b1;
               w_pw_nx       = c_PW'(1);
            end
         end

         ST_HUNT: begin
            if (w_mid) begin
               w_bit_cnt_nx = c_BW'(1);
               w_shift_nx   = w_shifted;
               if (w_shifted == 8'hD5) begin
                  w_state_nx = ST_DATA;
                  w_dv_nx    = 1'b1;
                  w_bcnt_nx  = 3'd0;
               end
            end else if (w_eoc) begin
               w_state_nx = ST_IDLE;
            end
         end

         ST_DATA: begin
            if (w_mid) begin
               w_bit_cnt_nx = c_BW'(1);
               w_shift_nx   = w_shifted;
               w_bcnt_nx    = r_bcnt + 3'd1;
               if (r_bcnt == 3'd7) begin
                  w_data_nx  = w_shifted;
                  w_valid_nx = 1'b1;
               end
            end else if (w_eoc) begin
               w_state_nx   = ST_IDLE;
               w_eof_nx     = 1'b1;
               w_dribble_nx = (r_bcnt != 3'd0);
               w_dv_nx      = 1'b0;
            end
         end

         default: begin
            w_state_nx = ST_IDLE;
            w_dv_nx    = 1'b0;
         end
      endcase
   end

   // Link integrity: a frame or a pair of timely NLPs asserts the link.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_link_ok  <= 1'b0;
         r_have_nlp <= 1'b0;
         r_tmr      <= 32'd0;
      end else if (w_nlp_nx || w_eof_nx) begin
         r_tmr <= 32'd0;
         if (w_nlp_nx) begin
            r_have_nlp <= 1'b1;
         end
         if (w_eof_nx || (r_have_nlp && (r_tmr < 32'(LINK_TIMEOUT)))) begin
            r_link_ok <= 1'b1;
         end
      end else if (r_tmr >= 32'(LINK_TIMEOUT)) begin
         r_link_ok  <= 1'b0;
         r_have_nlp <= 1'b0;
      end else begin
         r_tmr <= r_tmr + 32'd1;
      end
   end

   assign rx_data    = r_data;
   assign rx_valid   = r_valid;
   assign rx_dv      = r_dv;
   assign rx_eof     = r_eof;
   assign rx_dribble = r_dribble;
   assign link_ok    = r_link_ok;
   assign nlp_seen   = r_nlp;

endmodule
`default_nettype wire
